// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential packed-BCD to binary converter.
// Reverse double-dabble, one shift-and-correct step per clock, with a start/busy/done handshake.
// Optional build macro BCD_DIGIT_CHECK_EN: digits above 9 are rejected in two cycles,
// returning bin=0 with err=1. Without it err is tied low and every digit pattern goes
// through the full shift sequence.
module bcd_to_bin_seq #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  reset_p,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned SrW  = BcdW + BIN_W;
    localparam int unsigned CntW = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StFinish
    } state_e;

    state_e              state_q, state_d;
    logic [SrW-1:0]      sr_q, sr_d;
    logic [SrW-1:0]      sr_step;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [BIN_W-1:0]    bin_q;
    logic                done_q;
    logic                accept;
    logic                bad_digit;

    assign accept = (state_q == StIdle) && start;

`ifdef BCD_DIGIT_CHECK_EN
    logic inv_q;
    logic err_q;

    // Flag any captured digit outside 0..9
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    // Remember the rejection across FINISH and hold err until the next accepted start
    always_ff @(posedge clk) begin
        if (reset_p) begin
            inv_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                inv_q <= bad_digit;
                err_q <= 1'b0;
            end else if (state_q == StFinish) begin
                err_q <= inv_q;
            end
        end
    end

    assign err = err_q;
`else
    assign bad_digit = 1'b0;
    assign err       = 1'b0;
`endif

    // One reverse double-dabble step: shift right, then take 3 off every BCD digit >= 8
    always_comb begin
        sr_step = sr_q >> 1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (sr_step[BIN_W + 4*i + 3]) begin
                sr_step[BIN_W + 4*i +: 4] = sr_step[BIN_W + 4*i +: 4] - 4'd3;
            end
        end
    end

    // Next-state, shift register and iteration counter
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sr_d    = {bcd, {BIN_W{1'b0}}};
                    cnt_d   = '0;
                    state_d = bad_digit ? StFinish : StShift;
                end
            end
            StShift: begin
                sr_d  = sr_step;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(BIN_W - 1)) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; result and done pulse are produced by the FINISH cycle
    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q <= StIdle;
            sr_q    <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            done_q  <= (state_q == StFinish);
            if (state_q == StFinish) begin
`ifdef BCD_DIGIT_CHECK_EN
                bin_q <= inv_q ? '0 : sr_q[BIN_W-1:0];
`else
                bin_q <= sr_q[BIN_W-1:0];
`endif
            end
        end
    end

    assign bin  = bin_q;
    assign done = done_q;
    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: directed boundary cases plus random operands,
// checked against a digit-level reference model.
module tb_bcd_to_bin_seq;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    logic                clk = 1'b0;
    logic                reset_p = 1'b1;
    logic                start = 1'b0;
    logic [4*DIGITS-1:0] bcd = '0;
    logic [BIN_W-1:0]    bin;
    logic                busy;
    logic                done;
    logic                err;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_to_bin_seq #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) dut (
        .clk     (clk),
        .reset_p (reset_p),
        .start   (start),
        .bcd     (bcd),
        .bin     (bin),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic bit has_bad_digit(input logic [15:0] b);
        for (int i = 0; i < DIGITS; i++) begin
            if (((b >> (4 * i)) & 16'hF) > 9) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Valid operands: plain decimal value. Invalid ones: the shift/correct recurrence
    // evaluated on an integer digit array.
    function automatic int algo_value(input logic [15:0] b);
        int d[DIGITS];
        int nd[DIGITS];
        int r;
        int dec;
        r   = 0;
        dec = 0;
        for (int i = 0; i < DIGITS; i++) d[i] = int'((b >> (4 * i)) & 16'hF);
        if (!has_bad_digit(b)) begin
            for (int i = DIGITS - 1; i >= 0; i--) dec = dec * 10 + d[i];
            return dec;
        end
        for (int s = 0; s < BIN_W; s++) begin
            r = (r >> 1) | ((d[0] % 2) << (BIN_W - 1));
            for (int i = 0; i < DIGITS; i++) begin
                nd[i] = d[i] / 2;
                if (i < DIGITS - 1 && (d[i + 1] % 2) == 1) nd[i] += 8;
                if (nd[i] >= 8) nd[i] -= 3;
            end
            d = nd;
        end
        return r;
    endfunction

    function automatic int exp_bin(input logic [15:0] b);
`ifdef BCD_DIGIT_CHECK_EN
        if (has_bad_digit(b)) return 0;
`endif
        return algo_value(b);
    endfunction

    function automatic int exp_err(input logic [15:0] b);
`ifdef BCD_DIGIT_CHECK_EN
        return has_bad_digit(b) ? 1 : 0;
`else
        return (b === b) ? 0 : 0;
`endif
    endfunction

    function automatic int exp_lat(input logic [15:0] b);
`ifdef BCD_DIGIT_CHECK_EN
        if (has_bad_digit(b)) return 1;
`endif
        return BIN_W + 1;
    endfunction

    // Issue one conversion from IDLE, scramble bcd after capture, poke start mid-flight
    task automatic convert(input logic [15:0] b, input string tag);
        int lat;
        int want_lat;
        want_lat = exp_lat(b);
        start = 1'b1;
        bcd   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        bcd   = 16'($urandom);
        check_eq({tag, " busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (1) begin
            @(posedge clk);
            #1;
            lat++;
            start = (lat == 5);
            if (done || lat > 40) break;
        end
        start = 1'b0;
        check_eq({tag, " latency"}, 32'(lat), 32'(want_lat));
        check_eq({tag, " bin"}, 32'(bin), 32'(exp_bin(b)));
        check_eq({tag, " err"}, 32'(err), 32'(exp_err(b)));
        @(posedge clk);
        #1;
        check_eq({tag, " done pulse"}, 32'(done), 32'd0);
        check_eq({tag, " bin held"}, 32'(bin), 32'(exp_bin(b)));
    endtask

    initial begin
        int n_done;
        logic [15:0] r;

        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        reset_p = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("reset bin", 32'(bin), 32'd0);
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset done", 32'(done), 32'd0);
        check_eq("reset err", 32'(err), 32'd0);

        // Directed cases
        convert(16'h1234, "h1234");
        check_eq("h1234 abs", 32'(bin), 32'h04D2);
        convert(16'h0000, "h0000");
        convert(16'h9999, "h9999");
        check_eq("h9999 abs", 32'(bin), 32'h270F);
        convert(16'h0001, "h0001");

        // start held high: two back-to-back conversions, bcd changes during SHIFT
        start = 1'b1;
        bcd   = 16'h0042;
        @(posedge clk);
        #1;
        n_done = 0;
        for (int e = 1; e <= 31; e++) begin
            @(posedge clk);
            #1;
            if (e == 3) bcd = 16'h0500;
            if (done) n_done++;
            if (e == 15) begin
                check_eq("b2b first done", 32'(done), 32'd1);
                check_eq("b2b first bin", 32'(bin), 32'd42);
            end
            if (e == 31) begin
                start = 1'b0;
                check_eq("b2b second done", 32'(done), 32'd1);
                check_eq("b2b second bin", 32'(bin), 32'd500);
            end
        end
        check_eq("b2b done count", 32'(n_done), 32'd2);
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check_eq("b2b no extra done", 32'(n_done), 32'd2);

        // Reset mid-SHIFT drops the conversion
        start = 1'b1;
        bcd   = 16'h7777;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset_p = 1'b1;
        @(posedge clk);
        #1;
        reset_p = 1'b0;
        check_eq("midreset bin", 32'(bin), 32'd0);
        check_eq("midreset busy", 32'(busy), 32'd0);
        check_eq("midreset done", 32'(done), 32'd0);
        check_eq("midreset err", 32'(err), 32'd0);
        n_done = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check_eq("midreset no done", 32'(n_done), 32'd0);
        convert(16'h0815, "h0815");

        // Invalid digit, then a valid operand clears err
        convert(16'h12A4, "h12A4");
        convert(16'h0099, "h0099");

        // Random valid operands
        for (int k = 0; k < 12; k++) begin
            r = '0;
            for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
            convert(r, $sformatf("rnd_valid_%0d", k));
        end
        // Random arbitrary nibbles
        for (int k = 0; k < 8; k++) begin
            r = 16'($urandom);
            convert(r, $sformatf("rnd_any_%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
